// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl -- Instruction Fetch Unit fetch sequencer.
//
// Owns the program counter and issues at most one outstanding read to the
// instruction memory at a time. Returned words are stored with their PC in
// a small FIFO and presented to decode over a valid/ready handshake.
// A redirect loads a new PC, flushes the FIFO and discards any response
// still in flight.
//
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   BUF_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports:
//   clk, reset                    clock (rising edge), async active-high reset
//   redirect_valid, redirect_pc   one-cycle redirect pulse and target PC
//   imem_req, imem_addr           memory read request (combinational) / address = PC
//   imem_rsp_valid, imem_rsp_data memory response strobe and instruction word
//   inst_valid, inst_ready        decode handshake for the buffer head
//   inst_pc, inst_code            PC and instruction word of the buffer head
//
// Optional build macro IFU_FETCH_HALT_EN adds:
//   fetch_halt  input  -- suppresses new requests while high
//   fetch_idle  output -- FSM in FETCH with an empty buffer
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_code
`ifdef IFU_FETCH_HALT_EN
  ,
  input  logic        fetch_halt,
  output logic        fetch_idle
`endif
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(BUF_DEPTH);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_code_q, head_code_d;

  logic [31:0] buf_pc_q   [BUF_DEPTH];
  logic [31:0] buf_code_q [BUF_DEPTH];

  logic halt;
  logic push;
  logic pop;
  logic head_from_push;

`ifdef IFU_FETCH_HALT_EN
  assign halt       = fetch_halt;
  assign fetch_idle = (state_q == FETCH) && (count_q == '0);
`else
  assign halt = 1'b0;
`endif

  // Reset gating keeps the request low for the whole reset pulse, not just
  // until the registers settle.
  assign imem_req   = !reset && (state_q == FETCH) && (count_q < DEPTH_C) &&
                      !redirect_valid && !halt;
  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_pc    = head_pc_q;
  assign inst_code  = head_code_q;

  assign pop = inst_valid && inst_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_pc_d   = head_pc_q;
    head_code_d = head_code_q;
    push        = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (imem_req) begin
          fetch_pc_d = pc_q;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (redirect_valid) begin
          // A response landing together with the redirect is stale; drop it.
          state_d = imem_rsp_valid ? FETCH : DRAIN;
        end else if (imem_rsp_valid) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end

    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_t'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
        rd_ptr_d = ptr_t'(rd_ptr_q + 1'b1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end

    // Head registers track the entry that will sit at the read pointer next
    // cycle; when the buffer goes empty they keep their last value.
    head_from_push = push && ((count_q == '0) || ((count_q == cnt_t'(1)) && pop));
    if (!redirect_valid) begin
      if (head_from_push) begin
        head_pc_d   = fetch_pc_q;
        head_code_d = imem_rsp_data;
      end else if (count_d != '0) begin
        head_pc_d   = buf_pc_q[rd_ptr_d];
        head_code_d = buf_code_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_pc_q   <= '0;
      head_code_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_pc_q   <= head_pc_d;
      head_code_q <= head_code_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
      buf_code_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_pc;
  logic [31:0] inst_code;
`ifdef IFU_FETCH_HALT_EN
  logic        fetch_halt = 1'b0;
  logic        fetch_idle;
  logic        w_fetch_idle;
`endif

  // Second instance exercising PC wrap from the top of the address space.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_inst_valid;
  logic [31:0] w_inst_pc;
  logic [31:0] w_inst_code;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  int unsigned lat = 1;
  logic        pend = 1'b0;
  int unsigned cnt = 0;
  logic [31:0] paddr = '0;

  ifu_fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_code      (inst_code)
`ifdef IFU_FETCH_HALT_EN
    ,
    .fetch_halt     (fetch_halt),
    .fetch_idle     (fetch_idle)
`endif
  );

  ifu_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_wrap (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .inst_valid     (w_inst_valid),
    .inst_ready     (1'b1),
    .inst_pc        (w_inst_pc),
    .inst_code      (w_inst_code)
`ifdef IFU_FETCH_HALT_EN
    ,
    .fetch_halt     (1'b0),
    .fetch_idle     (w_fetch_idle)
`endif
  );

  // Memory model: returns 32'h13 + address, 'lat' cycles after the request.
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= 32'h13 + paddr;
        pend           <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (imem_req) begin
      if (lat <= 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= 32'h13 + imem_addr;
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  always @(posedge clk) begin
    w_rsp_valid <= w_req;
    w_rsp_data  <= 32'h13 + w_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // ---- reset values ----
    #1 reset = 1'b1;
    repeat (3) step();
    chk("rst_req",   {31'b0, imem_req},   32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_pc",    inst_pc,             32'h0);
    chk("rst_code",  inst_code,           32'h0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_waddr", w_addr,              32'hFFFF_FFFC);
    chk("rst_wreq",  {31'b0, w_req},      32'h0);

    // ---- streaming, 1-cycle memory; wrap instance alongside ----
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("run_req",  {31'b0, imem_req}, 32'h1);
      chk("run_addr", imem_addr, 32'(4 * i));
      if (i > 0) begin
        chk("run_valid", {31'b0, inst_valid}, 32'h1);
        chk("run_ipc",   inst_pc,   32'(4 * (i - 1)));
        chk("run_code",  inst_code, 32'h13 + 32'(4 * (i - 1)));
      end
      if (i == 0) begin
        chk("wrap_req0",  {31'b0, w_req}, 32'h1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      end
      if (i == 1) begin
        chk("wrap_req1",   {31'b0, w_req}, 32'h1);
        chk("wrap_addr1",  w_addr,         32'h0);
        chk("wrap_valid",  {31'b0, w_inst_valid}, 32'h1);
        chk("wrap_ipc",    w_inst_pc,      32'hFFFF_FFFC);
        chk("wrap_code",   w_inst_code,    32'h0000_000F);
      end
      step();
      chk("run_req_gap",   {31'b0, imem_req},   32'h0);
      chk("run_valid_gap", {31'b0, inst_valid}, 32'h0);
      step();
    end
    chk("run_last_valid", {31'b0, inst_valid}, 32'h1);
    chk("run_last_ipc",   inst_pc,   32'd12);
    chk("run_last_code",  inst_code, 32'h1F);

    // ---- backpressure ----
    inst_ready = 1'b0;
    reset_pulse();
    chk("bp_req0",  {31'b0, imem_req}, 32'h1);
    chk("bp_addr0", imem_addr, 32'h0);
    step(); step();
    chk("bp_ipc0",  inst_pc,   32'h0);
    chk("bp_addr4", imem_addr, 32'h4);
    step(); step();
    chk("bp_full_req",   {31'b0, imem_req}, 32'h0);
    chk("bp_full_addr",  imem_addr, 32'h8);
    chk("bp_full_ipc",   inst_pc,   32'h0);
    step();
    chk("bp_hold_req",   {31'b0, imem_req}, 32'h0);
    chk("bp_hold_addr",  imem_addr, 32'h8);
    inst_ready = 1'b1;
    step();
    chk("bp_pop_ipc",    inst_pc,   32'h4);
    chk("bp_resume_req", {31'b0, imem_req}, 32'h1);
    chk("bp_resume_addr", imem_addr, 32'h8);
    step();
    chk("bp_empty", {31'b0, inst_valid}, 32'h0);
    step();
    chk("bp_ipc8",  inst_pc,   32'h8);
    chk("bp_code8", inst_code, 32'h1B);

    // ---- redirect in WAIT_RSP, 3-cycle memory ----
    lat = 3;
    reset_pulse();
    chk("rd_req0", {31'b0, imem_req}, 32'h1);
    step(); step(); step(); step();
    chk("rd_ipc0",  inst_pc,   32'h0);
    chk("rd_addr4", imem_addr, 32'h4);
    step();
    chk("rd_wait_req", {31'b0, imem_req}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", {31'b0, inst_valid}, 32'h0);
    chk("rd_new_addr",    imem_addr, 32'h0000_0100);
    chk("rd_drain_req",   {31'b0, imem_req}, 32'h0);
    step();
    chk("rd_drain_req2",  {31'b0, imem_req}, 32'h0);
    chk("rd_drop_valid",  {31'b0, inst_valid}, 32'h0);
    step();
    chk("rd_next_req",    {31'b0, imem_req}, 32'h1);
    chk("rd_next_addr",   imem_addr, 32'h0000_0100);
    chk("rd_stale_valid", {31'b0, inst_valid}, 32'h0);

    // ---- redirect coincident with response ----
    lat = 1;
    reset_pulse();
    step();
    chk("co_wait_req", {31'b0, imem_req}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("co_nopush", {31'b0, inst_valid}, 32'h0);
    chk("co_req",    {31'b0, imem_req}, 32'h1);
    chk("co_addr",   imem_addr, 32'h40);
    step(); step();
    chk("co_ipc",  inst_pc,   32'h40);
    chk("co_code", inst_code, 32'h53);

    // ---- async reset mid-WAIT_RSP with pc = 0x20 ----
    inst_ready = 1'b0;
    reset_pulse();
    step(); step();
    chk("ar_code0", inst_code, 32'h13);
    lat = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("ar_req20",  {31'b0, imem_req}, 32'h1);
    chk("ar_addr20", imem_addr, 32'h20);
    chk("ar_held",   inst_code, 32'h13);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_addr",  imem_addr, 32'h0);
    chk("ar_req",   {31'b0, imem_req}, 32'h0);
    chk("ar_valid", {31'b0, inst_valid}, 32'h0);
    chk("ar_code",  inst_code, 32'h0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("ar_post_req",  {31'b0, imem_req}, 32'h1);
    chk("ar_post_addr", imem_addr, 32'h0);
    step();
    chk("ar_late_drop", {31'b0, inst_valid}, 32'h0);
    step(); step(); step();
    chk("ar_good_valid", {31'b0, inst_valid}, 32'h1);
    chk("ar_good_code",  inst_code, 32'h13);
    inst_ready = 1'b1;

`ifdef IFU_FETCH_HALT_EN
    // ---- fetch halt ----
    lat = 1;
    reset_pulse();
    step();
    fetch_halt = 1'b1;
    step();
    chk("h_push",  {31'b0, inst_valid}, 32'h1);
    chk("h_req",   {31'b0, imem_req},   32'h0);
    chk("h_busy",  {31'b0, fetch_idle}, 32'h0);
    step();
    chk("h_req2",  {31'b0, imem_req},   32'h0);
    chk("h_idle",  {31'b0, fetch_idle}, 32'h1);
    chk("h_addr",  imem_addr, 32'h4);
    fetch_halt = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
